// File: rtl/rom_arbiter.sv
// Round-robin arbiter that shares one synchronous-read ROM between fetch (0) and load (1).
// Each grant is tagged and carried through a pipeline that matches the ROM read latency.
module rom_arbiter #(
    parameter int Width       = 32,
    parameter int Depth       = 32,
    parameter int AddrWidth   = 30,
    parameter int ReadLatency = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [AddrWidth-1:0] req0_addr,
    output logic                 req0_ready,
    output logic                 resp0_valid,
    output logic [Width-1:0]     resp0_data,
    output logic                 resp0_err,
    input  logic                 req1_valid,
    input  logic [AddrWidth-1:0] req1_addr,
    output logic                 req1_ready,
    output logic                 resp1_valid,
    output logic [Width-1:0]     resp1_data,
    output logic                 resp1_err,
    output logic [AddrWidth-1:0] rom_addr,
    input  logic [Width-1:0]     rom_data
);

    localparam logic [AddrWidth-1:0] DepthLimit = AddrWidth'(Depth);
    localparam int Last = ReadLatency - 1;

    logic                   last_grant;
    logic                   grant0;
    logic                   grant1;
    logic                   transfer;
    logic                   addr_err;
    logic [ReadLatency-1:0] tag_valid;
    logic [ReadLatency-1:0] tag_id;
    logic [ReadLatency-1:0] tag_err;

    // On contention the requester not granted last time wins.
    always_comb begin
        grant0   = req0_valid && (!req1_valid || last_grant);
        grant1   = req1_valid && !grant0;
        transfer = grant0 || grant1;
        rom_addr = '0;
        if (grant0) begin
            rom_addr = req0_addr;
        end else if (grant1) begin
            rom_addr = req1_addr;
        end
        addr_err = rom_addr >= DepthLimit;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            tag_valid  <= '0;
            tag_id     <= '0;
            tag_err    <= '0;
        end else begin
            if (transfer) begin
                last_grant <= grant1;
            end
            tag_valid[0] <= transfer;
            tag_id[0]    <= grant1;
            tag_err[0]   <= transfer && addr_err;
            for (int i = 1; i < ReadLatency; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
                tag_err[i]   <= tag_err[i-1];
            end
        end
    end

    // The ROM word is only forwarded for in-range reads; errored reads return zero.
    always_comb begin
        resp0_valid = 1'b0;
        resp0_data  = '0;
        resp0_err   = 1'b0;
        resp1_valid = 1'b0;
        resp1_data  = '0;
        resp1_err   = 1'b0;
        if (tag_valid[Last]) begin
            if (tag_id[Last]) begin
                resp1_valid = 1'b1;
                resp1_err   = tag_err[Last];
                resp1_data  = tag_err[Last] ? '0 : rom_data;
            end else begin
                resp0_valid = 1'b1;
                resp0_err   = tag_err[Last];
                resp0_data  = tag_err[Last] ? '0 : rom_data;
            end
        end
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares one synchronous-read `Rom` between two requesters. Requester 0 is instruction fetch; requester 1 is the data/load path. Arbitration is round-robin with a per-cycle valid/ready handshake. The block tracks the ROM's fixed read latency and routes each returned word, with an out-of-range flag, back to the requester that issued it. It sits between the processor's fetch/load units and the single `Rom` instance.

## Interface

Parameters:
- `Width`, 32: ROM data width in bits.
- `Depth`, 32: number of ROM words; legal addresses are 0..Depth-1.
- `AddrWidth`, 30: word-address width.
- `ReadLatency`, 1: clock edges from address capture to valid `rom_data`; legal range 1..4.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  fetch request present.
- `req0_addr`  in  AddrWidth  fetch word address.
- `req0_ready`  out  1  fetch request granted this cycle.
- `resp0_valid`  out  1  fetch response present; single-cycle pulse.
- `resp0_data`  out  Width  fetch response word.
- `resp0_err`  out  1  fetch address was >= Depth.
- `req1_valid`, `req1_addr`, `req1_ready`, `resp1_valid`, `resp1_data`, `resp1_err`: identical to the requester-0 ports, for the load path.
- `rom_addr`  out  AddrWidth  address to the `Rom` `addr` port.
- `rom_data`  in  Width  from the `Rom` `data` port.

## Operation

Grant logic (combinational):
- Only one valid request: that requester is granted.
- Both requests valid: the requester *not* named by `last_grant` is granted.
- A transfer occurs when `reqN_valid && reqN_ready`. At most one `reqN_ready` is high per cycle.
- `reqN_ready` never asserts without `reqN_valid`.

Arbiter state:
- `last_grant` updates to the granted index on every transfer and holds otherwise.
- Reset value of `last_grant` is 1, so requester 0 wins the first contended cycle.

ROM address:
- `rom_addr` is the granted requester's address.
- With no grant, `rom_addr` is 0.

Response tracking:
- A `ReadLatency`-deep shift register carries a tag per stage: `{valid, id, err}`.
- On a transfer, the tag `{1, id, addr >= Depth}` enters stage 0. With no transfer, `{0, x, 0}` enters.
- The comparison `addr >= Depth` is done at full `AddrWidth`, unsigned.

Response output:
- When the last stage is valid, `resp[id]_valid` = 1 for exactly one cycle.
- If the tag's `err` = 0: `resp[id]_data` = `rom_data` and `resp[id]_err` = 0.
- If the tag's `err` = 1: `resp[id]_data` = 0 and `resp[id]_err` = 1.
- The other requester's response outputs are all 0.
- Responses cannot be back-pressured. Requesters must always accept them.
- Each requester receives its responses in issue order. Across requesters, responses follow global grant order.

Reset (asynchronous):
- All tag stages are cleared and `last_grant` is set to 1.
- `resp*_valid`, `resp*_err` and `resp*_data` are 0.
- `req*_ready` follows the grant logic and is therefore 0 while no request is valid.

## Timing

- Grant is combinational, in the same cycle as `reqN_valid`.
- Throughput: one grant per cycle, sustained.
- A request granted in cycle T produces its response in cycle T+ReadLatency.
- Back-to-back grants in T and T+1 produce responses in consecutive cycles, with no bubbles.
- A requester holding `valid` during contention wins within 2 cycles, so there is no starvation.
- Requester-side rule: `req_addr` must be stable while `valid` is high and `ready` is low. The arbiter does not latch it.
- A request and a response for the same requester in the same cycle are independent. Both proceed.
- Reset asserted mid-flight:
  - all outstanding tags are discarded, and no response is emitted for them;
  - after deassertion, the first response appears no earlier than ReadLatency cycles after the first new grant.

## Test plan

Setup: ROM preloaded with `rom[i] = i+1`. Default `ReadLatency` = 1 unless a scenario states otherwise.

- **Single requester streaming.** Drive `req0_valid` with addr 0..31, one per cycle. Required: `req0_ready` stays high, and `resp0_data` = 1..32 on consecutive cycles starting one cycle after the first grant.
- **Contention alternation.** Hold both valid, with `req0_addr` = 3 and `req1_addr` = 7, for 6 cycles. Required:
  - grants go 0,1,0,1,0,1;
  - `resp0_data` = 4 and `resp1_data` = 8 on alternating cycles;
  - exactly one `resp*_valid` high per cycle.
- **Out of range.** Issue `req1_addr` = 32, then `req1_addr` = 0x3FFFFFFF. Required: each response has `resp1_err` = 1 and `resp1_data` = 0. A following `req1_addr` = 31 returns 32 with `err` = 0.
- **Reset mid-flight.** Grant `req0_addr` = 5, then assert `reset` before the next edge. Required: no `resp0_valid`, all outputs 0 during reset. After release, the first contended grant goes to requester 0.
- **Latency parameter.** With `ReadLatency` = 3, issue addr 2, 4 and 6 back-to-back from requester 1. Required: `resp1_data` = 3, 5, 7 in cycles T+3, T+4, T+5.
- **Idle and no spurious ready.** Both valid low for 10 cycles. Required: `req*_ready` = 0, `rom_addr` = 0, no `resp*_valid`.
